// File: rtl/fifo_ms_rr_drain.sv
// Round-robin drain for the multi-stream FIFO: grants one non-empty flow per cycle, absorbs the
// one-cycle read latency in a 2-entry buffer and merges all flows onto one valid/ready stream.
module fifo_ms_rr_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  localparam int TAG_W     = $clog2(FLUX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLUX-1:0]             fifo_empty,
  output logic [FLUX-1:0]             fifo_read,
  input  logic [TAG_W+DATA_WIDTH-1:0] fifo_dout,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [TAG_W-1:0]            m_tag,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        tag_err
);

  localparam int WORD_W = TAG_W + DATA_WIDTH;

  logic [TAG_W-1:0]  rr_ptr_reg;
  logic [TAG_W-1:0]  inflight_id_reg;
  logic              inflight_reg;
  logic [1:0]        occ_reg;
  logic              head_reg;
  logic              tag_err_reg;
  logic [WORD_W-1:0] buf_mem [2];

  logic              pop;
  logic              issue_ok;
  logic              any_req;
  logic              issue;
  logic [TAG_W-1:0]  grant;
  logic [TAG_W-1:0]  rr_next;
  logic [TAG_W:0]    idx_w;
  logic              tail;
  logic [1:0]        occ_next;

  assign pop      = m_valid & m_ready;
  // Buffered words plus the one in flight, less the one leaving, must leave a free slot.
  assign issue_ok = ({1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop}) < 3'd2;

  // Walk the flows from the highest offset down so the last hit is the nearest to rr_ptr.
  always_comb begin
    grant   = rr_ptr_reg;
    any_req = 1'b0;
    idx_w   = '0;
    for (int k = FLUX - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr_reg} + (TAG_W + 1)'(k);
      if (idx_w >= (TAG_W + 1)'(FLUX)) begin
        idx_w = idx_w - (TAG_W + 1)'(FLUX);
      end
      if (!fifo_empty[idx_w[TAG_W-1:0]]) begin
        grant   = idx_w[TAG_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Gated by rst so the strobe drops the instant reset is asserted.
  assign issue   = rst & issue_ok & any_req;
  assign rr_next = (grant == TAG_W'(FLUX - 1)) ? '0 : grant + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_read
      assign fifo_read[gi] = issue & (grant == TAG_W'(gi));
    end
  endgenerate

  assign tail     = head_reg ^ occ_reg[0];
  assign occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg      <= '0;
      inflight_id_reg <= '0;
      inflight_reg    <= 1'b0;
      occ_reg         <= 2'd0;
      head_reg        <= 1'b0;
      tag_err_reg     <= 1'b0;
      buf_mem[0]      <= '0;
      buf_mem[1]      <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_id_reg <= grant;
        rr_ptr_reg      <= rr_next;
      end
      // A returning word is always forwarded, even when its tag disagrees with the grant.
      if (inflight_reg) begin
        buf_mem[tail] <= fifo_dout;
        if (fifo_dout[WORD_W-1:DATA_WIDTH] != inflight_id_reg) begin
          tag_err_reg <= 1'b1;
        end
      end
      occ_reg <= occ_next;
      if (pop) begin
        head_reg <= ~head_reg;
      end
    end
  end

  assign m_valid          = (occ_reg != 2'd0);
  assign {m_tag, m_data}  = buf_mem[head_reg];
  assign tag_err          = tag_err_reg;

endmodule

// File: tb/tb_fifo_ms_rr_drain.sv
// Bench for fifo_ms_rr_drain: a two-flow FIFO model feeds the DUT, a scoreboard checks the merged
// output stream, and directed checks cover read strobes, latency, backpressure, tag errors and reset.
module tb_fifo_ms_rr_drain;

  localparam int DW = 8;
  localparam int FX = 2;
  localparam int TW = 1;
  localparam int WW = TW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FX-1:0] fifo_empty = 2'b11;
  logic [FX-1:0] fifo_read;
  logic [WW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic          tag_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [WW-1:0] q0[$];
  logic [WW-1:0] q1[$];
  logic [WW-1:0] exp_q[$];
  logic [1:0]    rd_log[$];
  int            rd_cyc[$];
  int            pop_cyc[$];
  logic [1:0]    rd_s = 2'b00;
  logic [WW-1:0] exp_w;

  fifo_ms_rr_drain #(.DATA_WIDTH(DW), .FLUX(FX)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_tag      (m_tag),
    .m_data     (m_data),
    .tag_err    (tag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples strobes and pops the scoreboard on every accepted output word.
  always @(negedge clk) begin
    rd_s = fifo_read;
    if (fifo_read != 2'b00) begin
      rd_log.push_back(fifo_read);
      rd_cyc.push_back(cyc);
    end
    if (m_valid && m_ready) begin
      pop_cyc.push_back(cyc);
      $display("out tag=%0d data=0x%02h cyc=%0d", m_tag, m_data, cyc);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no output", {m_tag, m_data});
      end else begin
        exp_w = exp_q.pop_front();
        chk("sb_word", 32'({m_tag, m_data}), 32'(exp_w));
      end
    end
  end

  // FIFO model: a strobe seen in cycle N yields the word during cycle N+1.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd_s == 2'b11) begin
      checks++;
      fails++;
      $display("FAIL read_onehot: got %b, expected one-hot", rd_s);
    end
    if (rd_s[0]) begin
      if (q0.size() == 0) begin
        checks++; fails++;
        $display("FAIL read_empty0: got read, expected none");
      end else fifo_dout <= q0.pop_front();
    end else if (rd_s[1]) begin
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL read_empty1: got read, expected none");
      end else fifo_dout <= q1.pop_front();
    end else begin
      fifo_dout <= 9'h1A5;
    end
    fifo_empty <= {q1.size() == 0, q0.size() == 0};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int f, input logic [WW-1:0] w);
    if (f == 0) q0.push_back(w);
    else        q1.push_back(w);
    fifo_empty[f] = 1'b0;
  endtask

  task automatic clr_logs();
    rd_log.delete();
    rd_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic chk_rd_seq(input string name, input int n);
    chk({name, "_count"}, 32'(rd_log.size()), 32'(n));
    if (rd_log.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk(name, 32'(rd_log[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      end
    end
  endtask

  initial begin
    // Reset held two cycles
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fifo_read", 32'(fifo_read), 32'h0);
    chk("rst_m_valid",   32'(m_valid),   32'h0);
    chk("rst_tag_err",   32'(tag_err),   32'h0);
    chk("rst_m_tag",     32'(m_tag),     32'h0);
    chk("rst_m_data",    32'(m_data),    32'h0);

    // Single flow, two words
    step(1);
    clr_logs();
    m_ready = 1'b1;
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    load(0, 9'h001);
    load(0, 9'h002);
    step(8);
    chk("t2_reads", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      chk("t2_rd0", 32'(rd_log[0]), 32'h1);
      chk("t2_rd1", 32'(rd_log[1]), 32'h1);
    end
    if (pop_cyc.size() == 2 && rd_cyc.size() >= 1) begin
      chk("t2_latency", 32'(pop_cyc[0] - rd_cyc[0]), 32'd2);
      chk("t2_b2b",     32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    end else begin
      chk("t2_pops", 32'(pop_cyc.size()), 32'd2);
    end

    // Two flows, round robin from a fresh pointer
    rst = 1'b0;
    exp_q.delete();
    step(1);
    rst = 1'b1;
    clr_logs();
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h101);
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h102);
    load(0, 9'h001);
    load(0, 9'h002);
    load(1, 9'h101);
    load(1, 9'h102);
    step(10);
    chk_rd_seq("t3_rd", 4);
    chk("t3_pops", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t3_b2b", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end

    // Backpressure: two reads then stall, head held
    clr_logs();
    m_ready = 1'b0;
    exp_q.push_back(9'h010);
    exp_q.push_back(9'h120);
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h121);
    exp_q.push_back(9'h012);
    exp_q.push_back(9'h122);
    load(0, 9'h010); load(0, 9'h011); load(0, 9'h012);
    load(1, 9'h120); load(1, 9'h121); load(1, 9'h122);
    step(6);
    chk_rd_seq("t4_stall_rd", 2);
    chk("t4_valid", 32'(m_valid), 32'h1);
    chk("t4_head",  32'({m_tag, m_data}), 32'h010);
    step(3);
    chk("t4_held",  32'({m_tag, m_data}), 32'h010);
    chk("t4_no_more_reads", 32'(rd_log.size()), 32'd2);
    m_ready = 1'b1;
    step(12);
    chk_rd_seq("t4_all_rd", 6);

    // Mismatched tag returned for a flow-0 read
    clr_logs();
    exp_q.push_back(9'h155);
    load(0, 9'h155);
    @(negedge clk);
    chk("t5_err_c0", 32'(tag_err), 32'h0);
    @(negedge clk);
    chk("t5_err_c1", 32'(tag_err), 32'h0);
    @(negedge clk);
    chk("t5_err_c2", 32'(tag_err), 32'h1);
    chk("t5_rd_flow0", 32'(rd_log.size() > 0 ? rd_log[0] : 2'b00), 32'h1);
    repeat (5) @(negedge clk);
    chk("t5_err_sticky", 32'(tag_err), 32'h1);

    // Reset while a read is in flight and a word is buffered
    step(1);
    clr_logs();
    m_ready = 1'b0;
    load(0, 9'h030); load(0, 9'h031); load(0, 9'h032);
    load(1, 9'h140); load(1, 9'h141); load(1, 9'h142);
    step(2);
    chk("t6_pre_valid", 32'(m_valid), 32'h1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", 32'(m_valid),   32'h0);
    chk("t6_rst_read",  32'(fifo_read), 32'h0);
    chk("t6_rst_err",   32'(tag_err),   32'h0);
    chk("t6_rst_word",  32'({m_tag, m_data}), 32'h0);
    step(1);
    chk("t6_rst_read_hold", 32'(fifo_read), 32'h0);
    clr_logs();
    rst = 1'b1;
    m_ready = 1'b1;
    exp_q.push_back(9'h031);
    exp_q.push_back(9'h141);
    exp_q.push_back(9'h032);
    exp_q.push_back(9'h142);
    step(10);
    chk_rd_seq("t6_rd", 4);
    chk("t6_err_clear", 32'(tag_err), 32'h0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
